// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end.
// Contents:
//   DW_DEF, N_DEF  default element width and matrix dimension
//   lanes_of()     lane count for an N x N array (2N-1)
//   elem_lsb()     bit offset of element/lane idx in a packed vector
//   feeder_state_e feeder FSM states
package systolic_pkg;

  localparam int DW_DEF = 8;
  localparam int N_DEF  = 3;

  function automatic int lanes_of(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int elem_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_wave_sel.sv
// Combinational wavefront selector.
// Given matrices A and B (row-major, element k at [k*DW +: DW]) and a
// wavefront index w, lane w+j of a carries A[w][j] and lane w+j of b
// carries B[j][w] for j = 0..N-1; every other lane is zero.
// Ports:
//   a_mat_i, b_mat_i  packed N*N matrices
//   wave_i            wavefront index (values >= N select all-zero lanes)
//   a_lane_o, b_lane_o packed 2N-1 lane vectors, lane L at [L*DW +: DW]
module skew_wave_sel
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF,
  parameter int WW = 2
) (
  input  logic [N*N*DW-1:0]     a_mat_i,
  input  logic [N*N*DW-1:0]     b_mat_i,
  input  logic [WW-1:0]         wave_i,
  output logic [(2*N-1)*DW-1:0] a_lane_o,
  output logic [(2*N-1)*DW-1:0] b_lane_o
);

  localparam int LANES = lanes_of(N);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;

    // Lane gi is fed by column j = gi - w of the current wavefront, if any.
    always_comb begin
      a_val = '0;
      b_val = '0;
      for (int j = 0; j < N; j++) begin
        if ((int'(wave_i) < N) && (int'(wave_i) + j == gi)) begin
          a_val = a_mat_i[elem_lsb(int'(wave_i) * N + j, DW) +: DW];
          b_val = b_mat_i[elem_lsb(j * N + int'(wave_i), DW) +: DW];
        end
      end
    end

    assign a_lane_o[elem_lsb(gi, DW) +: DW] = a_val;
    assign b_lane_o[elem_lsb(gi, DW) +: DW] = b_val;
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for the N x N systolic multiplier array.
// Accepts one (A, B) matrix pair, then replays it as N diagonal
// wavefronts (one per clock) followed by DRAIN_CYCLES of zero lanes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand pair handshake (ready only in IDLE)
//   a_mat_i, b_mat_i  row-major packed operand matrices
//   a_lane_o, b_lane_o registered 2N-1 lane outputs
//   feed_active_o     high while wavefronts are on the lanes
//   busy_o            high from accept through the last drain cycle
//   frame_done_o      one-cycle pulse on the last drain cycle
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int N            = N_DEF,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*N*DW-1:0]        a_mat_i,
  input  logic [N*N*DW-1:0]        b_mat_i,
  output logic [(2*N-1)*DW-1:0]    a_lane_o,
  output logic [(2*N-1)*DW-1:0]    b_lane_o,
  output logic                     feed_active_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int LANES = lanes_of(N);
  localparam int MW    = N * N * DW;
  localparam int LW    = LANES * DW;
  localparam int WW    = (N > 1) ? $clog2(N) : 1;
  localparam int DCW   = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WW-1:0]  LAST_WAVE  = WW'(N - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

  feeder_state_e  state_q, state_d;
  logic [WW-1:0]  wave_cnt_q, wave_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic [MW-1:0]  a_cap_q, a_cap_d;
  logic [MW-1:0]  b_cap_q, b_cap_d;
  logic [LW-1:0]  a_lane_q, a_lane_d;
  logic [LW-1:0]  b_lane_q, b_lane_d;

  logic [MW-1:0]  sel_a;
  logic [MW-1:0]  sel_b;
  logic [WW-1:0]  sel_wave;
  logic [LW-1:0]  sel_a_lane;
  logic [LW-1:0]  sel_b_lane;

  // The selector always computes the wavefront to be registered at the
  // next edge. In IDLE that is wave 0 of the live inputs, since the
  // capture registers only load at the accepting edge itself.
  always_comb begin
    if (state_q == IDLE) begin
      sel_a    = a_mat_i;
      sel_b    = b_mat_i;
      sel_wave = '0;
    end else begin
      sel_a    = a_cap_q;
      sel_b    = b_cap_q;
      sel_wave = wave_cnt_q + WW'(1);
    end
  end

  skew_wave_sel #(
    .DW (DW),
    .N  (N),
    .WW (WW)
  ) u_sel (
    .a_mat_i  (sel_a),
    .b_mat_i  (sel_b),
    .wave_i   (sel_wave),
    .a_lane_o (sel_a_lane),
    .b_lane_o (sel_b_lane)
  );

  always_comb begin
    state_d     = state_q;
    wave_cnt_d  = wave_cnt_q;
    drain_cnt_d = drain_cnt_q;
    a_cap_d     = a_cap_q;
    b_cap_d     = b_cap_q;
    a_lane_d    = '0;
    b_lane_d    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_cap_d    = a_mat_i;
          b_cap_d    = b_mat_i;
          wave_cnt_d = '0;
          a_lane_d   = sel_a_lane;
          b_lane_d   = sel_b_lane;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (wave_cnt_q == LAST_WAVE) begin
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          wave_cnt_d = wave_cnt_q + WW'(1);
          a_lane_d   = sel_a_lane;
          b_lane_d   = sel_b_lane;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == LAST_DRAIN) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wave_cnt_q  <= '0;
      drain_cnt_q <= '0;
      a_cap_q     <= '0;
      b_cap_q     <= '0;
      a_lane_q    <= '0;
      b_lane_q    <= '0;
    end else begin
      state_q     <= state_d;
      wave_cnt_q  <= wave_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      a_cap_q     <= a_cap_d;
      b_cap_q     <= b_cap_d;
      a_lane_q    <= a_lane_d;
      b_lane_q    <= b_lane_d;
    end
  end

  assign a_lane_o      = a_lane_q;
  assign b_lane_o      = b_lane_q;
  assign in_ready      = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign feed_active_o = (state_q == FEED);
  assign frame_done_o  = (state_q == DRAIN) && (drain_cnt_q == LAST_DRAIN);

endmodule
